// File: rtl/speed_tracker_if.sv
// Update-command channel for speed_tracker: valid/ready plus instruction and torque.
// Latency: none, wires only.
// Backpressure: the master holds upd_valid and its payload until it sees upd_ready.
interface speed_tracker_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] instruction;
  logic [2:0] torque;

  modport master (
    output upd_valid,
    output instruction,
    output torque,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  instruction,
    input  torque,
    output upd_ready
  );
endinterface

// File: rtl/speed_tracker.sv
// Two-wheel velocity tracker with saturating arithmetic and a BCD seven-segment readout.
// Latency: handshake to done is VEL_W+3 cycles, clear to done is VEL_W+2 cycles.
// Backpressure: upd_ready is high only in IDLE with clear low. Define SPEED_TRACKER_LZB_EN to blank zero tens digits.

// Active-low segment decoder {g,f,e,d,c,b,a}; code 12 and other non-digits are blank.
module seven_seg (
  input  logic [3:0] code,
  output logic [6:0] seg
);
  // Map each digit code to its segment pattern
  always_comb begin
    seg = 7'b1111111;
    case (code)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module speed_tracker #(
  parameter int VEL_W    = 7,
  parameter int VEL_MAX  = 99,
  parameter int ACC_STEP = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  speed_tracker_if.slave   upd,
  output logic [VEL_W-1:0] vel_l,
  output logic [VEL_W-1:0] vel_r,
  output logic             done,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX7
);
  localparam int AW = VEL_W + 1;
  localparam logic [AW:0]      MAX_X = (AW+1)'(VEL_MAX);
  localparam logic [VEL_W-1:0] MAX_V = VEL_W'(VEL_MAX);
  localparam logic [2:0]       LAST  = 3'(VEL_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_t;

  state_t state, state_nx;

  logic [1:0]       ins_q;
  logic [2:0]       tq_q;
  logic [2:0]       cnt;
  logic [VEL_W-1:0] bin_l, bin_r;
  logic [7:0]       bcd_l, bcd_r;
  logic [7:0]       adj_l, adj_r;
  logic [3:0]       dig_lt, dig_lu, dig_rt, dig_ru;
  logic [3:0]       code_lt, code_lu, code_rt, code_ru;
  logic [2:0]       t_eff;
  logic [AW-1:0]    s, si;
  logic [VEL_W-1:0] nx_l, nx_r;
  logic             hs;

  // Saturate at VEL_MAX; the extra carry bit catches any overflow of the AW-bit sum.
  function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] v, input logic [AW-1:0] d);
    logic [AW:0] sum;
    sum = (AW+1)'(v) + (AW+1)'(d);
    if (sum > MAX_X) return MAX_V;
    return sum[VEL_W-1:0];
  endfunction

  // Clamp at zero instead of wrapping.
  function automatic logic [VEL_W-1:0] sat_sub(input logic [VEL_W-1:0] v, input logic [AW-1:0] d);
    logic [AW-1:0] diff;
    if (d > AW'(v)) return '0;
    diff = AW'(v) - d;
    return diff[VEL_W-1:0];
  endfunction

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign upd.upd_ready = reset_n & (state == IDLE) & ~clear;
  assign hs            = upd.upd_valid & upd.upd_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: clear beats a pending command; CONV runs one cycle per binary bit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clear)   state_nx = CONV;
        else if (hs) state_nx = CALC;
      end
      CALC: state_nx = CONV;
      CONV: if (cnt == LAST) state_nx = LOAD;
      LOAD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Step sizes and new wheel velocities from the latched command
  always_comb begin
    t_eff = (tq_q > 3'd4) ? 3'd0 : tq_q;
    s     = AW'(ACC_STEP * int'(t_eff));
    si    = (t_eff == 3'd0) ? '0 : AW'(ACC_STEP * (int'(t_eff) - 1));
    nx_l  = vel_l;
    nx_r  = vel_r;
    case (ins_q)
      2'b00: begin nx_l = sat_add(vel_l, s);  nx_r = sat_add(vel_r, s);  end
      2'b01: begin nx_l = sat_sub(vel_l, s);  nx_r = sat_sub(vel_r, s);  end
      2'b10: begin nx_l = sat_add(vel_l, si); nx_r = sat_add(vel_r, s);  end
      default: begin nx_l = sat_add(vel_l, s); nx_r = sat_add(vel_r, si); end
    endcase
    adj_l = {adj3(bcd_l[7:4]), adj3(bcd_l[3:0])};
    adj_r = {adj3(bcd_r[7:4]), adj3(bcd_r[3:0])};
  end

  // Datapath: command latch, velocity update, shift-add-3 conversion, digit load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_q  <= '0;
      tq_q   <= '0;
      cnt    <= '0;
      vel_l  <= '0;
      vel_r  <= '0;
      bin_l  <= '0;
      bin_r  <= '0;
      bcd_l  <= '0;
      bcd_r  <= '0;
      dig_lt <= '0;
      dig_lu <= '0;
      dig_rt <= '0;
      dig_ru <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == LOAD);
      case (state)
        IDLE: begin
          if (clear) begin
            vel_l <= '0;
            vel_r <= '0;
            bin_l <= '0;
            bin_r <= '0;
            bcd_l <= '0;
            bcd_r <= '0;
            cnt   <= '0;
          end else if (hs) begin
            ins_q <= upd.instruction;
            tq_q  <= upd.torque;
          end
        end
        CALC: begin
          vel_l <= nx_l;
          vel_r <= nx_r;
          bin_l <= nx_l;
          bin_r <= nx_r;
          bcd_l <= '0;
          bcd_r <= '0;
          cnt   <= '0;
        end
        CONV: begin
          {bcd_l, bin_l} <= (8+VEL_W)'({adj_l, bin_l, 1'b0});
          {bcd_r, bin_r} <= (8+VEL_W)'({adj_r, bin_r, 1'b0});
          cnt <= cnt + 3'd1;
        end
        LOAD: begin
          dig_lt <= bcd_l[7:4];
          dig_lu <= bcd_l[3:0];
          dig_rt <= bcd_r[7:4];
          dig_ru <= bcd_r[3:0];
        end
        default: ;
      endcase
    end
  end

  // Segment codes: optional leading-zero blanking, then the enable blank override
  always_comb begin
    code_lt = dig_lt;
    code_lu = dig_lu;
    code_rt = dig_rt;
    code_ru = dig_ru;
`ifdef SPEED_TRACKER_LZB_EN
    if (dig_lt == 4'd0) code_lt = 4'd12;
    if (dig_rt == 4'd0) code_rt = 4'd12;
`else
`endif
    if (!enable) begin
      code_lt = 4'd12;
      code_lu = 4'd12;
      code_rt = 4'd12;
      code_ru = 4'd12;
    end
  end

  seven_seg u_hex4 (.code(code_rt), .seg(HEX4));
  seven_seg u_hex5 (.code(code_ru), .seg(HEX5));
  seven_seg u_hex6 (.code(code_lt), .seg(HEX6));
  seven_seg u_hex7 (.code(code_lu), .seg(HEX7));
endmodule

// File: tb/tb_speed_tracker.sv
// Bench for speed_tracker: directed scenarios plus randomized commands against an arithmetic model.
// Latency: checks handshake/clear to done timing in cycles.
// Backpressure: waits on upd_ready with a bounded cycle budget.
module tb_speed_tracker;
  localparam int VEL_W    = 7;
  localparam int VEL_MAX  = 99;
  localparam int ACC_STEP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic [VEL_W-1:0] vel_l, vel_r;
  logic done;
  logic [6:0] HEX4, HEX5, HEX6, HEX7;

  speed_tracker_if upd_if ();

  speed_tracker #(.VEL_W(VEL_W), .VEL_MAX(VEL_MAX), .ACC_STEP(ACC_STEP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .upd(upd_if),
    .vel_l(vel_l), .vel_r(vel_r), .done(done),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_l = 0;
  int m_r = 0;

  function automatic int clampv(input int v);
    if (v > VEL_MAX) return VEL_MAX;
    if (v < 0) return 0;
    return v;
  endfunction

  // Reference: wheel velocities as plain integers
  function automatic void model_cmd(input int ins, input int tq);
    int t, st, si;
    t  = (tq > 4) ? 0 : tq;
    st = ACC_STEP * t;
    si = (t == 0) ? 0 : ACC_STEP * (t - 1);
    case (ins)
      0: begin m_l = clampv(m_l + st); m_r = clampv(m_r + st); end
      1: begin m_l = clampv(m_l - st); m_r = clampv(m_r - st); end
      2: begin m_l = clampv(m_l + si); m_r = clampv(m_r + st); end
      default: begin m_l = clampv(m_l + st); m_r = clampv(m_r + si); end
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // idx 0..3 = HEX4..HEX7 = right tens, right units, left tens, left units
  function automatic logic [6:0] exp_hex(input int idx, input bit en);
    int v, d;
    v = (idx < 2) ? m_r : m_l;
    d = (idx % 2 == 0) ? v / 10 : v % 10;
`ifdef SPEED_TRACKER_LZB_EN
    if (idx % 2 == 0 && d == 0) d = 12;
`endif
    if (!en) d = 12;
    return seg_of(d);
  endfunction

  function automatic logic [6:0] hex_now(input int idx);
    case (idx)
      0: return HEX4;
      1: return HEX5;
      2: return HEX6;
      default: return HEX7;
    endcase
  endfunction

  task automatic send(input logic [1:0] ins, input logic [2:0] tq, output int lat,
                      output int rdy_hi, output logic [27:0] mid_hex, output int mid_vl);
    int w;
    lat = 0; rdy_hi = 0; mid_hex = '0; mid_vl = -1;
    @(negedge clk);
    upd_if.upd_valid = 1'b1; upd_if.instruction = ins; upd_if.torque = tq;
    w = 0;
    while (!upd_if.upd_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_wait: upd_ready never high within %0d cycles", w);
      upd_if.upd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    upd_if.upd_valid = 1'b0;
    upd_if.instruction = 2'($urandom);
    upd_if.torque = 3'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      if (upd_if.upd_ready) rdy_hi++;
      if (lat == 2) begin mid_hex = {HEX7, HEX6, HEX5, HEX4}; mid_vl = int'(vel_l); end
      @(negedge clk);
      lat++;
    end
    model_cmd(int'(ins), int'(tq));
  endtask

  task automatic do_clear(output int lat);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    m_l = 0; m_r = 0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    upd_if.upd_valid = 1'b0; upd_if.instruction = 2'd0; upd_if.torque = 3'd0;
    @(negedge clk);
    n_cmp++; if (int'(vel_l) !== 0 || int'(vel_r) !== 0) begin n_bad++; $display("FAIL reset_vel: got %0d/%0d want 0/0", vel_l, vel_r); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (upd_if.upd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", upd_if.upd_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL reset_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (upd_if.upd_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", upd_if.upd_ready); end
  endtask

  task automatic test_forward;
    int lat, rh, mv; logic [27:0] mh, old_hex;
    old_hex = {exp_hex(3, 1'b1), exp_hex(2, 1'b1), exp_hex(1, 1'b1), exp_hex(0, 1'b1)};
    send(2'b00, 3'd3, lat, rh, mh, mv);
    n_cmp++; if (lat !== VEL_W + 3) begin n_bad++; $display("FAIL fwd_latency: got %0d want %0d", lat, VEL_W + 3); end
    n_cmp++; if (rh !== 0) begin n_bad++; $display("FAIL fwd_ready_busy: ready high %0d cycles want 0", rh); end
    n_cmp++; if (mv !== m_l) begin n_bad++; $display("FAIL fwd_vel_after_calc: got %0d want %0d", mv, m_l); end
    n_cmp++; if (mh !== old_hex) begin n_bad++; $display("FAIL fwd_hex_held: got %h want %h", mh, old_hex); end
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL fwd_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    n_cmp++; if (upd_if.upd_ready !== 1'b1) begin n_bad++; $display("FAIL fwd_ready_done: got %b want 1", upd_if.upd_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL fwd_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_saturation;
    int lat, rh, mv; logic [27:0] mh;
    for (int k = 0; k < 17; k++) send(2'b00, 3'd4, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL sat_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL sat_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
  endtask

  task automatic test_underflow;
    int lat, rh, mv; logic [27:0] mh;
    do_clear(lat);
    n_cmp++; if (lat !== VEL_W + 2) begin n_bad++; $display("FAIL clear_latency: got %0d want %0d", lat, VEL_W + 2); end
    send(2'b00, 3'd2, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL under_setup_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    send(2'b01, 3'd4, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL under_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
  endtask

  task automatic test_turns;
    int lat, rh, mv; logic [27:0] mh;
    do_clear(lat);
    send(2'b10, 3'd2, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL left_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    send(2'b11, 3'd1, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL right_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL turn_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
  endtask

  task automatic test_clear_priority;
    int k;
    @(negedge clk);
    clear = 1'b1; upd_if.upd_valid = 1'b1; upd_if.instruction = 2'b00; upd_if.torque = 3'd1;
    #1;
    n_cmp++; if (upd_if.upd_ready !== 1'b0) begin n_bad++; $display("FAIL clrpri_ready: got %b want 0", upd_if.upd_ready); end
    @(negedge clk);
    clear = 1'b0;
    m_l = 0; m_r = 0;
    k = 1;
    while (!done && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (k !== VEL_W + 2) begin n_bad++; $display("FAIL clrpri_latency: got %0d want %0d", k, VEL_W + 2); end
    n_cmp++; if (int'(vel_l) !== 0 || int'(vel_r) !== 0) begin n_bad++; $display("FAIL clrpri_vel: got %0d/%0d want 0/0", vel_l, vel_r); end
    n_cmp++; if (upd_if.upd_ready !== 1'b1) begin n_bad++; $display("FAIL clrpri_pending_accept: got %b want 1", upd_if.upd_ready); end
    @(negedge clk);
    upd_if.upd_valid = 1'b0;
    model_cmd(0, 1);
    k = 1;
    while (!done && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (k !== VEL_W + 3) begin n_bad++; $display("FAIL clrpri_cmd_latency: got %0d want %0d", k, VEL_W + 3); end
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL clrpri_cmd_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    upd_if.upd_valid = 1'b1; upd_if.instruction = 2'b00; upd_if.torque = 3'd4;
    @(negedge clk);
    upd_if.upd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    m_l = 0; m_r = 0;
    #1;
    n_cmp++; if (int'(vel_l) !== 0 || int'(vel_r) !== 0) begin n_bad++; $display("FAIL midrst_vel: got %0d/%0d want 0/0", vel_l, vel_r); end
    n_cmp++; if (upd_if.upd_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", upd_if.upd_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL midrst_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin @(negedge clk); if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
    n_cmp++; if (int'(vel_l) !== 0 || int'(vel_r) !== 0) begin n_bad++; $display("FAIL midrst_discard: got %0d/%0d want 0/0", vel_l, vel_r); end
  endtask

  task automatic test_enable;
    int lat, rh, mv; logic [27:0] mh;
    @(negedge clk);
    enable = 1'b0;
    send(2'b00, 3'd3, lat, rh, mh, mv);
    n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL en_vel: got %0d/%0d want %0d/%0d", vel_l, vel_r, m_l, m_r); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b0)) begin n_bad++; $display("FAIL en_blank_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b0)); end
    end
    enable = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (hex_now(i) !== exp_hex(i, 1'b1)) begin n_bad++; $display("FAIL en_restore_hex%0d: got %b want %b", i + 4, hex_now(i), exp_hex(i, 1'b1)); end
    end
  endtask

  task automatic test_random;
    int lat, rh, mv, want; logic [27:0] mh; bit en;
    for (int it = 0; it < 60; it++) begin
      en = ($urandom_range(0, 3) != 0);
      enable = en;
      if ($urandom_range(0, 7) == 0) begin
        do_clear(lat);
        want = VEL_W + 2;
      end else begin
        send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), lat, rh, mh, mv);
        want = VEL_W + 3;
      end
      n_cmp++; if (lat !== want) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, want); end
      n_cmp++; if (int'(vel_l) !== m_l || int'(vel_r) !== m_r) begin n_bad++; $display("FAIL rnd%0d_vel: got %0d/%0d want %0d/%0d", it, vel_l, vel_r, m_l, m_r); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (hex_now(i) !== exp_hex(i, en)) begin n_bad++; $display("FAIL rnd%0d_hex%0d: got %b want %b", it, i + 4, hex_now(i), exp_hex(i, en)); end
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_saturation;
    test_underflow;
    test_turns;
    test_clear_priority;
    test_reset_mid;
    test_enable;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
